// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS main control unit: state encoding,
// opcode/funct constants, datapath select encodings and the control word.
package mips_pkg;

    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC     = 4'd7,
        S_ALUWB    = 4'd8,
        S_IMMEXEC  = 4'd9,
        S_IMMWB    = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JR       = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_ADDIMM = 2'b11;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    typedef struct packed {
        logic       read;
        logic       write;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_en;
        logic       active;
    } ctrl_t;

    // Quiescent control word: nothing strobed, machine still running.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.active = 1'b1;
        return c;
    endfunction

    // Dispatch target out of DECODE; unknown opcodes fall back to FETCH as a NOP.
    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_t s;
        case (op)
            OP_LW, OP_SW: s = S_MEMADR;
            OP_RTYPE:     s = (fn == FUNCT_JR) ? S_JR : S_EXEC;
            OP_ADDIU:     s = S_IMMEXEC;
            OP_BEQ:       s = S_BRANCH;
            OP_J:         s = S_JUMP;
            default:      s = S_FETCH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch, decode and the
// per-class execute/writeback steps, with memory stalls and a jr-to-zero halt.
module mips_main_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       jr_target_zero,
    input  logic       waitrequest,
    output logic       read,
    output logic       write,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       pc_en,
    output logic       active,
    output state_t     dbg_state
);

    // Memory handshake: read/write is a request held steady with its address
    // select; the access completes in the first cycle waitrequest is low, and
    // only then may the FSM leave the memory state.
    state_t state;
    state_t next_state;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_START;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_START:    next_state = S_FETCH;
            S_FETCH:    next_state = waitrequest ? S_FETCH : S_DECODE;
            S_DECODE:   next_state = decode_next(opcode, funct);
            S_MEMADR:   next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = waitrequest ? S_MEMREAD : S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: next_state = waitrequest ? S_MEMWRITE : S_FETCH;
            S_EXEC:     next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_IMMEXEC:  next_state = S_IMMWB;
            S_IMMWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
            S_JR:       next_state = jr_target_zero ? S_HALT : S_FETCH;
            S_HALT:     next_state = S_HALT;
            default:    next_state = S_START;
        endcase
    end

    always_comb begin
        ctrl = ctrl_idle();
        case (state)
            S_FETCH: begin
                ctrl.read      = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_ALU;
                ctrl.ir_write  = !waitrequest;
                ctrl.pc_en     = !waitrequest;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMREAD: begin
                ctrl.read   = 1'b1;
                ctrl.i_or_d = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.write  = 1'b1;
                ctrl.i_or_d = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_IMMEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADDIMM;
            end
            S_IMMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            // The branch target was parked in ALUOut during DECODE.
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PC_ALUOUT;
                ctrl.pc_en     = zero;
            end
            S_JUMP: begin
                ctrl.pc_source = PC_JUMP;
                ctrl.pc_en     = 1'b1;
            end
            S_JR: begin
                ctrl.pc_source = PC_RS;
                ctrl.pc_en     = 1'b1;
            end
            S_HALT: begin
                ctrl.active = 1'b0;
            end
            default: ctrl = ctrl_idle();
        endcase
    end

    assign read       = ctrl.read;
    assign write      = ctrl.write;
    assign alu_op     = ctrl.alu_op;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_source  = ctrl.pc_source;
    assign i_or_d     = ctrl.i_or_d;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign pc_en      = ctrl.pc_en;
    assign active     = ctrl.active;
    assign dbg_state  = state;

endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench for mips_main_control: directed table, instruction-level
// random model feeding a per-cycle expected queue, and async reset corners.
module tb_mips_main_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       jr_target_zero;
    logic       waitrequest;
    logic       read, write, alu_src_a, i_or_d, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, pc_en, active;
    logic [1:0] alu_op, alu_src_b, pc_source;
    state_t     dbg_state;

    mips_main_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .jr_target_zero(jr_target_zero), .waitrequest(waitrequest),
        .read(read), .write(write), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .i_or_d(i_or_d),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .pc_en(pc_en), .active(active), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       jz;
        logic       wr;
        string      tag;
    } stim_t;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        jz;
        logic        wr;
        logic [15:0] exp;
        string       tag;
    } vec_t;

    stim_t       stim_q[$];
    logic [15:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] act_vec;

    assign act_vec = {read, write, alu_op, alu_src_a, alu_src_b, pc_source, i_or_d,
                      ir_write, reg_dst, mem_to_reg, reg_write, pc_en, active};

    function automatic logic [15:0] mk(input logic rd, input logic wr, input logic [1:0] aop,
                                       input logic sa, input logic [1:0] sb, input logic [1:0] ps,
                                       input logic iod, input logic irw, input logic rdst,
                                       input logic m2r, input logic rw, input logic pce,
                                       input logic act);
        return {rd, wr, aop, sa, sb, ps, iod, irw, rdst, m2r, rw, pce, act};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic jz, input logic wr, input logic [15:0] e, input string tag);
        stim_t s;
        s.op = op; s.fn = fn; s.z = z; s.jz = jz; s.wr = wr; s.tag = tag;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Expected control words, written straight from the state descriptions.
    function automatic logic [15:0] e_start();  return mk(0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0,0,1); endfunction
    function automatic logic [15:0] e_fwait();  return mk(1,0,2'b00,0,2'b01,2'b00,0,0,0,0,0,0,1); endfunction
    function automatic logic [15:0] e_fgo();    return mk(1,0,2'b00,0,2'b01,2'b00,0,1,0,0,0,1,1); endfunction
    function automatic logic [15:0] e_decode(); return mk(0,0,2'b00,0,2'b11,2'b00,0,0,0,0,0,0,1); endfunction
    function automatic logic [15:0] e_memadr(); return mk(0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0,0,1); endfunction
    function automatic logic [15:0] e_memrd();  return mk(1,0,2'b00,0,2'b00,2'b00,1,0,0,0,0,0,1); endfunction
    function automatic logic [15:0] e_memwb();  return mk(0,0,2'b00,0,2'b00,2'b00,0,0,0,1,1,0,1); endfunction
    function automatic logic [15:0] e_memwr();  return mk(0,1,2'b00,0,2'b00,2'b00,1,0,0,0,0,0,1); endfunction
    function automatic logic [15:0] e_exec();   return mk(0,0,2'b10,1,2'b00,2'b00,0,0,0,0,0,0,1); endfunction
    function automatic logic [15:0] e_aluwb();  return mk(0,0,2'b00,0,2'b00,2'b00,0,0,1,0,1,0,1); endfunction
    function automatic logic [15:0] e_immex();  return mk(0,0,2'b11,1,2'b10,2'b00,0,0,0,0,0,0,1); endfunction
    function automatic logic [15:0] e_immwb();  return mk(0,0,2'b00,0,2'b00,2'b00,0,0,0,0,1,0,1); endfunction
    function automatic logic [15:0] e_branch(input logic z); return mk(0,0,2'b01,1,2'b00,2'b01,0,0,0,0,0,z,1); endfunction
    function automatic logic [15:0] e_jump();   return mk(0,0,2'b00,0,2'b00,2'b10,0,0,0,0,0,1,1); endfunction
    function automatic logic [15:0] e_jr();     return mk(0,0,2'b00,0,2'b00,2'b11,0,0,0,0,0,1,1); endfunction
    function automatic logic [15:0] e_halt();   return mk(0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0,0,0); endfunction

    // Instruction-level reference: expands one instruction into its cycle-by-cycle
    // expected control words; inputs a state ignores are randomized.
    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input logic jz, input int fstall, input int mstall);
        for (int i = 0; i < fstall; i++) push(op, fn, rb(), rb(), 1'b1, e_fwait(), "fetch_wait");
        push(op, fn, rb(), rb(), 1'b0, e_fgo(), "fetch");
        push(op, fn, rb(), rb(), rb(), e_decode(), "decode");
        if (op == OP_LW) begin
            push(op, fn, rb(), rb(), rb(), e_memadr(), "memadr");
            for (int i = 0; i < mstall; i++) push(op, fn, rb(), rb(), 1'b1, e_memrd(), "memread_wait");
            push(op, fn, rb(), rb(), 1'b0, e_memrd(), "memread");
            push(op, fn, rb(), rb(), rb(), e_memwb(), "memwb");
        end else if (op == OP_SW) begin
            push(op, fn, rb(), rb(), rb(), e_memadr(), "memadr");
            for (int i = 0; i < mstall; i++) push(op, fn, rb(), rb(), 1'b1, e_memwr(), "memwrite_wait");
            push(op, fn, rb(), rb(), 1'b0, e_memwr(), "memwrite");
        end else if (op == OP_RTYPE && fn == FUNCT_JR) begin
            push(op, fn, rb(), jz, rb(), e_jr(), "jr");
            if (jz) for (int i = 0; i < 10; i++) push(op, fn, rb(), rb(), rb(), e_halt(), "halt");
        end else if (op == OP_RTYPE) begin
            push(op, fn, rb(), rb(), rb(), e_exec(), "exec");
            push(op, fn, rb(), rb(), rb(), e_aluwb(), "aluwb");
        end else if (op == OP_ADDIU) begin
            push(op, fn, rb(), rb(), rb(), e_immex(), "immexec");
            push(op, fn, rb(), rb(), rb(), e_immwb(), "immwb");
        end else if (op == OP_BEQ) begin
            push(op, fn, z, rb(), rb(), e_branch(z), "branch");
        end else if (op == OP_J) begin
            push(op, fn, rb(), rb(), rb(), e_jump(), "jump");
        end
    endtask

    // ---------------- driver ----------------
    // Entered and left just after a rising edge; each entry is one clock cycle.
    task automatic run_q();
        stim_t       s;
        logic [15:0] e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            opcode = s.op; funct = s.fn; zero = s.z; jr_target_zero = s.jz; waitrequest = s.wr;
            @(negedge clk);
            check(s.tag, act_vec, e);
            check({s.tag, "_rw_excl"}, 16'(read & write), 16'h0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        opcode = 6'($urandom); funct = 6'($urandom);
        zero = rb(); jr_target_zero = rb(); waitrequest = rb();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_reset", act_vec, e_start());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [5:0] rand_undef();
        logic [5:0] op;
        do op = 6'($urandom);
        while (op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_ADDIU ||
               op == OP_BEQ || op == OP_J);
        return op;
    endfunction

    // Watchdog: every wait is on the free-running clock, this is a last resort.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        vec_t dir_tab[5];
        int   pick;
        logic [5:0] rfn;

        dir_tab[0] = '{6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0, e_start(),  "addu_start"};
        dir_tab[1] = '{6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0, e_fgo(),    "addu_fetch"};
        dir_tab[2] = '{6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0, e_decode(), "addu_decode"};
        dir_tab[3] = '{6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0, e_exec(),   "addu_exec"};
        dir_tab[4] = '{6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0, e_aluwb(),  "addu_aluwb"};

        do_reset();
        for (int i = 0; i < 5; i++)
            push(dir_tab[i].op, dir_tab[i].fn, dir_tab[i].z, dir_tab[i].jz, dir_tab[i].wr,
                 dir_tab[i].exp, dir_tab[i].tag);
        run_q();

        gen_instr(OP_LW, 6'h00, 1'b0, 1'b0, 0, 3);
        gen_instr(OP_BEQ, 6'h00, 1'b1, 1'b0, 0, 0);
        gen_instr(OP_BEQ, 6'h00, 1'b0, 1'b0, 1, 0);
        gen_instr(6'b111111, 6'h00, 1'b0, 1'b0, 0, 0);
        gen_instr(OP_SW, 6'h00, 1'b0, 1'b0, 2, 2);
        gen_instr(OP_ADDIU, 6'h00, 1'b0, 1'b0, 0, 0);
        gen_instr(OP_J, 6'h00, 1'b0, 1'b0, 0, 0);
        gen_instr(OP_RTYPE, FUNCT_JR, 1'b0, 1'b0, 0, 0);
        run_q();

        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 7);
            do rfn = 6'($urandom); while (rfn == FUNCT_JR);
            case (pick)
                0: gen_instr(OP_LW, rfn, rb(), 1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
                1: gen_instr(OP_SW, rfn, rb(), 1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
                2: gen_instr(OP_RTYPE, rfn, rb(), 1'b0, $urandom_range(0, 3), 0);
                3: gen_instr(OP_ADDIU, rfn, rb(), 1'b0, $urandom_range(0, 3), 0);
                4: gen_instr(OP_BEQ, rfn, rb(), 1'b0, $urandom_range(0, 3), 0);
                5: gen_instr(OP_J, rfn, rb(), 1'b0, $urandom_range(0, 3), 0);
                6: gen_instr(OP_RTYPE, FUNCT_JR, rb(), 1'b0, $urandom_range(0, 3), 0);
                default: gen_instr(rand_undef(), rfn, rb(), 1'b0, $urandom_range(0, 3), 0);
            endcase
        end
        run_q();

        // jr to address zero halts the machine for good
        gen_instr(OP_RTYPE, FUNCT_JR, 1'b0, 1'b1, 0, 0);
        run_q();

        // Reset asserted in the middle of a stalled store
        do_reset();
        push(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, e_start(), "rst2_start");
        push(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, e_fgo(), "rst2_fetch");
        push(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, e_decode(), "rst2_decode");
        push(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, e_memadr(), "rst2_memadr");
        push(OP_SW, 6'h00, 1'b0, 1'b0, 1'b1, e_memwr(), "rst2_memwrite_wait");
        push(OP_SW, 6'h00, 1'b0, 1'b0, 1'b1, e_memwr(), "rst2_memwrite_wait");
        run_q();
        waitrequest = 1'b1;
        #2;
        check("mw_before_rst", act_vec, e_memwr());
        rst_n = 1'b0;
        #1;
        check("mw_async_rst", act_vec, e_start());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(OP_SW, 6'h00, 1'b0, 1'b0, 1'b1, e_start(), "post_rst_start");
        push(OP_SW, 6'h00, 1'b0, 1'b0, 1'b1, e_fwait(), "post_rst_fetch_wait");
        push(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, e_fgo(), "post_rst_fetch");
        run_q();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_main_control.md
MIPS_MAIN_CONTROL -- requirements
Module: mips_main_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 6 bits: instr[31:26] from the instruction register.
REQ-004 SHALL have port funct, input, 6 bits: instr[5:0], used only to detect jr (6'b001000).
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port jr_target_zero, input, 1 bit: high when the rs value equals 32'h0.
REQ-007 SHALL have port waitrequest, input, 1 bit: memory stall.
REQ-008 SHALL have ports read and write, outputs, 1 bit each: memory strobes.
REQ-009 SHALL have port alu_op, output, 2 bits: 00 add, 01 sub, 10 funct-decoded, 11 add-immediate; consumed by the ALU control decoder.
REQ-010 SHALL have control outputs: alu_src_a (1 bit), alu_src_b (2 bits: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2), pc_source (2 bits: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs), i_or_d, ir_write, reg_dst, mem_to_reg, reg_write, pc_en (1 bit each).
REQ-011 SHALL have port active, output, 1 bit: high while executing, low once halted.

Function
REQ-012 SHALL be a multicycle Moore FSM with states START, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC, ALUWB, IMMEXEC, IMMWB, BRANCH, JUMP, JR, HALT.
REQ-013 START: all strobes 0; next state FETCH unconditionally.
REQ-014 FETCH: read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00; while waitrequest=1, hold in FETCH with ir_write=0 and pc_en=0; when waitrequest=0, assert ir_write=1 and pc_en=1 (pc_source=00) and go to DECODE.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: 100011/101011 MEMADR, 000000 JR if funct=001000 else EXEC, 001001 IMMEXEC, 000100 BRANCH, 000010 JUMP; any other opcode goes to FETCH as a NOP.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; lw goes to MEMREAD, sw goes to MEMWRITE.
REQ-017 MEMREAD: read=1, i_or_d=1; hold while waitrequest=1; then MEMWB.
REQ-018 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
REQ-019 MEMWRITE: write=1, i_or_d=1; hold while waitrequest=1; then FETCH.
REQ-020 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-021 IMMEXEC: alu_src_a=1, alu_src_b=10, alu_op=11; then IMMWB. IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero; then FETCH.
REQ-023 JUMP: pc_source=10, pc_en=1; then FETCH.
REQ-024 JR: pc_source=11, pc_en=1; next state HALT if jr_target_zero=1, else FETCH.
REQ-025 HALT: active=0, all strobes 0; remains in HALT until reset.
REQ-026 Every output not listed for a state SHALL be 0.
REQ-027 read/write, i_or_d and the ALU selects SHALL stay constant across waitrequest stall cycles.
REQ-028 read and write SHALL never be high in the same cycle.

Reset
REQ-029 rst_n low SHALL immediately force state to START, setting all strobes 0 and active=1, including when reset is asserted mid-transfer.
REQ-030 After rst_n rises, the first FETCH SHALL occur on the second rising edge.

Structure
REQ-031 Package mips_pkg SHALL hold the state enum, opcode/funct constants, and alu_op, alu_src_b and pc_source encodings.
REQ-032 The block SHALL be a single module with no sub-module: one async-reset state register plus combinational next-state and output blocks.

Verification
REQ-033 Reset, then addu (opcode 0, funct 100001), waitrequest=0 -> states START, FETCH, DECODE, EXEC (alu_op=10), ALUWB (reg_write=1, reg_dst=1).
REQ-034 lw with waitrequest=1 for 3 cycles in MEMREAD -> read=1 and i_or_d=1 held 4 cycles, then MEMWB with mem_to_reg=1.
REQ-035 beq with zero=1 -> pc_en=1, pc_source=01 in BRANCH; repeat with zero=0 -> pc_en=0.
REQ-036 jr with jr_target_zero=1 -> pc_en=1 in JR, then HALT with active=0 and no read for 10 cycles.
REQ-037 rst_n low during a MEMWRITE stall -> write drops in the same cycle; after release, START then FETCH.
REQ-038 Undefined opcode 6'b111111 -> DECODE goes to FETCH with no reg_write, write or pc_en asserted.
